// File: rtl/sar_pkg.sv
// SAR front-end shared types: FSM state encoding,
// data width and default conversion timeout.
package sar_pkg;

  localparam int SAR_W           = 8;
  localparam int TIMEOUT_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT,
    ST_DONE
  } sar_state_e;

endpackage

// File: rtl/sar_trial_checker.sv
// Comparator plus expected-trial tracker for a SAR engine.
// Ports: clk, rst; clear_i (drop seq_err), init_i (load first
// trial), active_i (CONVERT), eoc_i, held_i, trial_i;
// cmp_o (held >= trial while active), seq_err_o (sticky).
import sar_pkg::*;

module sar_trial_checker (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             init_i,
  input  logic             active_i,
  input  logic             eoc_i,
  input  logic [SAR_W-1:0] held_i,
  input  logic [SAR_W-1:0] trial_i,
  output logic             cmp_o,
  output logic             seq_err_o
);

  localparam int BW = $clog2(SAR_W);

  logic [SAR_W-1:0] exp_q, exp_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             dec_q, dec_d;
  logic             err_q, err_d;

  assign cmp_o     = active_i & (held_i >= trial_i);
  assign seq_err_o = err_q;

  always_comb begin
    exp_d = exp_q;
    bit_d = bit_q;
    dec_d = dec_q;
    err_d = err_q;
    if (clear_i) begin
      err_d = 1'b0;
    end
    if (init_i) begin
      exp_d = SAR_W'(1) << (SAR_W - 1);
      bit_d = BW'(SAR_W - 1);
      dec_d = 1'b0;
    end else if (active_i) begin
      // The EOC cycle may legally carry any code.
      if (!eoc_i && trial_i != exp_q) begin
        err_d = 1'b1;
      end
      // Once bit 0 is decided the expected code is frozen.
      if (!dec_q) begin
        if (!cmp_o) begin
          exp_d[bit_q] = 1'b0;
        end
        if (bit_q != '0) begin
          exp_d[bit_q - BW'(1)] = 1'b1;
        end else begin
          dec_d = 1'b1;
        end
        bit_d = bit_q - BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= '0;
      bit_q <= '0;
      dec_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      bit_q <= bit_d;
      dec_q <= dec_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/sar_frontend_model.sv
// Sample/hold + comparator front end wrapped around an external
// SAR engine: FSM, timeout counter and result capture.
// Ports: clk, rst (sync, high); sample_i, start_i; trial_i,
// eoc_i from SAR; cmp_o, sar_rst_n_o to SAR; busy_o,
// result_o, result_valid_o, match_o, seq_err_o, timeout_o.
import sar_pkg::*;

module sar_frontend_model #(
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SAR_W-1:0] sample_i,
  input  logic             start_i,
  input  logic [SAR_W-1:0] trial_i,
  input  logic             eoc_i,
  output logic             cmp_o,
  output logic             sar_rst_n_o,
  output logic             busy_o,
  output logic [SAR_W-1:0] result_o,
  output logic             result_valid_o,
  output logic             match_o,
  output logic             seq_err_o,
  output logic             timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  sar_state_e       state_q, state_d;
  logic [SAR_W-1:0] held_q, held_d;
  logic [SAR_W-1:0] res_q, res_d;
  logic             match_q, match_d;
  logic             rv_q, rv_d;
  logic             to_q, to_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic start_ok;
  logic in_conv;

  assign start_ok = (state_q == ST_IDLE) & start_i;
  assign in_conv  = (state_q == ST_CONVERT);

  assign busy_o         = (state_q != ST_IDLE);
  assign sar_rst_n_o    = in_conv | (state_q == ST_DONE);
  assign result_o       = res_q;
  assign result_valid_o = rv_q;
  assign match_o        = match_q;
  assign timeout_o      = to_q;

  sar_trial_checker u_chk (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (start_ok),
    .init_i   (state_q == ST_SAMPLE),
    .active_i (in_conv),
    .eoc_i    (eoc_i),
    .held_i   (held_q),
    .trial_i  (trial_i),
    .cmp_o    (cmp_o),
    .seq_err_o(seq_err_o)
  );

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    res_d   = res_q;
    match_d = match_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          held_d  = sample_i;
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        cnt_d   = '0;
        state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        cnt_d = cnt_q + CW'(1);
        // EOC outranks a timeout landing on the same cycle.
        if (eoc_i) begin
          res_d   = trial_i;
          match_d = (trial_i == held_q);
          rv_d    = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
      res_q   <= '0;
      match_q <= 1'b0;
      rv_q    <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      res_q   <= res_d;
      match_q <= match_d;
      rv_q    <= rv_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
